// File: rtl/router_pkg.sv
// Shared types and helpers for the data router: FSM states, window mode
// and the width of the unsigned column index.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  typedef enum logic {
    MODE_DW = 1'b0,
    MODE_PW = 1'b1
  } mode_t;

  // Wide enough for col_base + x*stride + kx with no wrap-around
  function automatic int idx_width(input int bufw, input int pox, input int ksize);
    return $clog2(bufw + 2 * pox + ksize) + 1;
  endfunction

endpackage

// File: rtl/router_col_mux.sv
// Stateless column selector: picks one line-buffer column for every row,
// returning zero for indices beyond the buffer (right padding).
module router_col_mux #(
  parameter int DW   = 32,
  parameter int POY  = 3,
  parameter int BUFW = 48,
  parameter int IW   = 8
) (
  input  logic [POY-1:0][BUFW-1:0][DW-1:0] line_data,
  input  logic [IW-1:0]                    idx,
  output logic [POY-1:0][DW-1:0]           pix
);

  // AND-OR mux; an out-of-range index matches no column and yields zero
  always_comb begin
    pix = '0;
    for (int y = 0; y < POY; y++) begin
      for (int c = 0; c < BUFW; c++) begin
        pix[y] = pix[y] | ((idx == IW'(c)) ? line_data[y][c] : '0);
      end
    end
  end

endmodule

// File: rtl/data_router_v2.sv
// Line-buffer to PE-array router: serves depthwise kernel windows or
// pointwise pixel columns from a registered POY x BUFW line buffer.
module data_router_v2
  import router_pkg::*;
#(
  parameter int DW    = 32,
  parameter int POY   = 3,
  parameter int POX   = 16,
  parameter int BUFW  = 48,
  parameter int KSIZE = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              cfg_mode,
  input  logic                              cfg_stride,
  input  logic [$clog2(BUFW)-1:0]           cfg_col_base,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [POY-1:0][BUFW-1:0][DW-1:0]  data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [POY-1:0][POX-1:0][DW-1:0]   dwpixel_array,
  output logic [POY-1:0][DW-1:0]            pwpixel_array,
  output logic                              blkend,
  output logic                              busy
);

  localparam int IW = idx_width(BUFW, POX, KSIZE);
  localparam int CW = $clog2(POX + KSIZE) + 1;
  localparam int BW = $clog2(BUFW);

  state_t                            state_r, state_s;
  mode_t                             mode_r;
  logic                              stride_r;
  logic [BW-1:0]                     col_base_r;
  logic [POY-1:0][BUFW-1:0][DW-1:0]  line_r, line_s;
  logic [CW-1:0]                     ky_r, kx_r, ky_s, kx_s, beat_kx_s;
  logic                              accept_s, fire_s, last_kx_s, last_ky_s;
  logic                              next_last_s, load_beat_s;
  logic                              out_valid_r, out_valid_s, blkend_r, blkend_s;
  logic [POY-1:0][POX-1:0][DW-1:0]   dw_r, dw_s;
  logic [POY-1:0][DW-1:0]            pw_r, pw_s;
  logic [IW-1:0]                     idx_s [POX];
  logic [POY-1:0][DW-1:0]            col_s [POX];

  assign in_ready      = (state_r == LOAD);
  assign busy          = (state_r != IDLE);
  assign out_valid     = out_valid_r;
  assign blkend        = blkend_r;
  assign dwpixel_array = dw_r;
  assign pwpixel_array = pw_r;

  // Handshake decodes and end-of-row / end-of-block detection
  always_comb begin
    accept_s  = (state_r == LOAD) && in_valid;
    fire_s    = out_valid_r && out_ready;
    last_kx_s = (mode_r == MODE_PW) ? (kx_r == CW'(POX - 1)) : (kx_r == CW'(KSIZE - 1));
    last_ky_s = (mode_r == MODE_PW) ? 1'b1 : (ky_r == CW'(KSIZE - 1));
  end

  // Next-state and beat counters
  always_comb begin
    state_s = state_r;
    ky_s    = ky_r;
    kx_s    = kx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
          ky_s    = '0;
          kx_s    = '0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          state_s = EMIT;
          kx_s    = '0;
        end else begin
          state_s = LOAD;
        end
      end
      EMIT: begin
        if (fire_s && last_kx_s) begin
          kx_s = '0;
          if (last_ky_s) begin
            state_s = IDLE;
            ky_s    = '0;
          end else begin
            state_s = LOAD;
            ky_s    = ky_r + CW'(1);
          end
        end else if (fire_s) begin
          kx_s = kx_r + CW'(1);
        end else begin
          kx_s = kx_r;
        end
      end
      default: begin
        state_s = IDLE;
        ky_s    = '0;
        kx_s    = '0;
      end
    endcase
  end

  // Describe the beat about to be presented: a fresh row starts at kx 0
  always_comb begin
    line_s      = accept_s ? data : line_r;
    beat_kx_s   = accept_s ? '0 : (kx_r + CW'(1));
    load_beat_s = accept_s || (fire_s && !last_kx_s);
    if (mode_r == MODE_PW) begin
      next_last_s = (beat_kx_s == CW'(POX - 1)) && last_ky_s;
    end else begin
      next_last_s = (beat_kx_s == CW'(KSIZE - 1)) && last_ky_s;
    end
  end

  // Column index per output lane; in PW mode every lane sees col_base + px
  always_comb begin
    for (int x = 0; x < POX; x++) begin
      if (mode_r == MODE_PW) begin
        idx_s[x] = IW'(col_base_r) + IW'(beat_kx_s);
      end else if (stride_r) begin
        idx_s[x] = IW'(col_base_r) + IW'(x * 2) + IW'(beat_kx_s);
      end else begin
        idx_s[x] = IW'(col_base_r) + IW'(x) + IW'(beat_kx_s);
      end
    end
  end

  for (genvar gx = 0; gx < POX; gx++) begin : g_col
    router_col_mux #(
      .DW   (DW),
      .POY  (POY),
      .BUFW (BUFW),
      .IW   (IW)
    ) u_col_mux (
      .line_data (line_s),
      .idx       (idx_s[gx]),
      .pix       (col_s[gx])
    );
  end

  // Output beat next values: load a new beat, retire the row, or hold
  always_comb begin
    out_valid_s = out_valid_r;
    blkend_s    = blkend_r;
    dw_s        = dw_r;
    pw_s        = pw_r;
    if (load_beat_s) begin
      out_valid_s = 1'b1;
      blkend_s    = next_last_s;
      for (int y = 0; y < POY; y++) begin
        for (int x = 0; x < POX; x++) begin
          dw_s[y][x] = (mode_r == MODE_DW) ? col_s[x][y] : '0;
        end
      end
      pw_s = (mode_r == MODE_PW) ? col_s[0] : '0;
    end else if (fire_s) begin
      out_valid_s = 1'b0;
      blkend_s    = 1'b0;
      dw_s        = '0;
      pw_s        = '0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // State, latched configuration, counters and line buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      mode_r     <= MODE_DW;
      stride_r   <= 1'b0;
      col_base_r <= '0;
      ky_r       <= '0;
      kx_r       <= '0;
      line_r     <= '0;
    end else begin
      state_r <= state_s;
      ky_r    <= ky_s;
      kx_r    <= kx_s;
      line_r  <= line_s;
      if ((state_r == IDLE) && start) begin
        mode_r     <= mode_t'(cfg_mode);
        stride_r   <= cfg_stride;
        col_base_r <= cfg_col_base;
      end
    end
  end

  // Registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      blkend_r    <= 1'b0;
      dw_r        <= '0;
      pw_r        <= '0;
    end else begin
      out_valid_r <= out_valid_s;
      blkend_r    <= blkend_s;
      dw_r        <= dw_s;
      pw_r        <= pw_s;
    end
  end

endmodule

// File: tb/tb_data_router_v2.sv
// Scoreboard bench for data_router_v2: expected beats are queued as input
// beats are driven and compared as the router presents its output beats.
module tb_data_router_v2;

  localparam int DW    = 32;
  localparam int POY   = 3;
  localparam int POX   = 16;
  localparam int BUFW  = 48;
  localparam int KSIZE = 3;
  localparam int BUDGET = 2000;

  typedef struct {
    logic [POY-1:0][POX-1:0][DW-1:0] dw;
    logic [POY-1:0][DW-1:0]          pw;
    logic                            blk;
  } beat_t;

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             start = 1'b0;
  logic                             cfg_mode = 1'b0;
  logic                             cfg_stride = 1'b0;
  logic [$clog2(BUFW)-1:0]          cfg_col_base = '0;
  logic                             in_valid = 1'b0;
  logic                             in_ready;
  logic [POY-1:0][BUFW-1:0][DW-1:0] data = '0;
  logic                             out_valid;
  logic                             out_ready = 1'b0;
  logic [POY-1:0][POX-1:0][DW-1:0]  dwpixel_array;
  logic [POY-1:0][DW-1:0]           pwpixel_array;
  logic                             blkend;
  logic                             busy;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    beats, blkends;
  beat_t sb[$];
  beat_t obs[$];

  data_router_v2 #(
    .DW(DW), .POY(POY), .POX(POX), .BUFW(BUFW), .KSIZE(KSIZE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
    .cfg_stride(cfg_stride), .cfg_col_base(cfg_col_base),
    .in_valid(in_valid), .in_ready(in_ready), .data(data),
    .out_valid(out_valid), .out_ready(out_ready),
    .dwpixel_array(dwpixel_array), .pwpixel_array(pwpixel_array),
    .blkend(blkend), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pv(input int ky, input int y, input int c);
    return (c < BUFW) ? DW'(ky * 4096 + y * 256 + c) : '0;
  endfunction

  task automatic fill_data(input int ky);
    for (int y = 0; y < POY; y++)
      for (int c = 0; c < BUFW; c++)
        data[y][c] = DW'(ky * 4096 + y * 256 + c);
  endtask

  task automatic push_expected(input logic mode, input logic stride, input int base, input int ky);
    beat_t e;
    int s;
    s = stride ? 2 : 1;
    if (mode) begin
      for (int px = 0; px < POX; px++) begin
        e.dw = '0;
        for (int y = 0; y < POY; y++) e.pw[y] = pv(ky, y, base + px);
        e.blk = (px == POX - 1);
        sb.push_back(e);
      end
    end else begin
      for (int kx = 0; kx < KSIZE; kx++) begin
        e.pw = '0;
        for (int y = 0; y < POY; y++)
          for (int x = 0; x < POX; x++)
            e.dw[y][x] = pv(ky, y, base + x * s + kx);
        e.blk = (ky == KSIZE - 1) && (kx == KSIZE - 1);
        sb.push_back(e);
      end
    end
  endtask

  // One block with scoreboard checking; poke drives start every busy cycle
  task automatic run_block(input logic mode, input logic stride, input int base,
                           input int rdy_pct, input logic poke);
    int    ld, budget;
    logic  acc_prev, stalled, done;
    beat_t cur, prev;
    beats = 0; blkends = 0; ld = 0; budget = 0;
    acc_prev = 1'b0; stalled = 1'b0; done = 1'b0;
    sb.delete(); obs.delete();
    prev.dw = '0; prev.pw = '0; prev.blk = 1'b0;
    @(negedge clk);
    start = 1'b1; cfg_mode = mode; cfg_stride = stride; cfg_col_base = 6'(base);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!done && budget < BUDGET) begin
      cur.dw = dwpixel_array; cur.pw = pwpixel_array; cur.blk = blkend;
      if (acc_prev) begin
        n_tests++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL valid_latency: out_valid=%b required 1", out_valid);
        end
      end
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || cur.dw !== prev.dw || cur.pw !== prev.pw || cur.blk !== prev.blk) begin
          n_fail++; $display("FAIL stall_hold: valid=%b blk=%b pw0=%h required 1 %b %h",
                             out_valid, cur.blk, cur.pw[0], prev.blk, prev.pw[0]);
        end
      end
      n_tests++;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL extra_beat: beat %0d with empty scoreboard", beats);
        end else if (cur.dw !== sb[0].dw || cur.pw !== sb[0].pw || cur.blk !== sb[0].blk) begin
          n_fail++; $display("FAIL beat_data: beat %0d got dw00=%h pw0=%h blk=%b required dw00=%h pw0=%h blk=%b",
                             beats, cur.dw[0][0], cur.pw[0], cur.blk, sb[0].dw[0][0], sb[0].pw[0], sb[0].blk);
        end
      end else if (blkend !== 1'b0) begin
        n_fail++; $display("FAIL blkend_idle: blkend=%b required 0", blkend);
      end
      if (busy !== 1'b1 && out_valid !== 1'b1) begin
        done = 1'b1;
        start = 1'b0;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
        if (poke) begin
          start = 1'b1; cfg_mode = ~mode;
        end
        if (out_valid === 1'b1 && out_ready) begin
          obs.push_back(cur);
          if (sb.size() > 0) void'(sb.pop_front());
          beats++;
          if (cur.blk === 1'b1) blkends++;
        end
        stalled = (out_valid === 1'b1) && !out_ready;
        prev = cur;
        if (in_ready === 1'b1) begin
          fill_data(ld);
          in_valid = 1'b1;
          push_expected(mode, stride, base, ld);
          ld++;
          acc_prev = 1'b1;
        end else begin
          in_valid = 1'b0;
          acc_prev = 1'b0;
        end
        @(negedge clk);
        budget++;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_mode = mode;
    n_tests++;
    if (!done || sb.size() != 0) begin
      n_fail++; $display("FAIL block_end: done=%b leftover=%0d required 1 0", done, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({out_valid, in_ready, blkend, busy} !== 4'b0000 || dwpixel_array !== '0 || pwpixel_array !== '0) begin
      n_fail++; $display("FAIL reset_state: v/r/b/busy=%b required 0000", {out_valid, in_ready, blkend, busy});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release: valid/busy=%b required 00", {out_valid, busy});
    end
  endtask

  task automatic test_dw_stride1();
    run_block(1'b0, 1'b0, 0, 100, 1'b0);
    n_tests++;
    if (beats != 9 || blkends != 1) begin
      n_fail++; $display("FAIL dw_s1_count: beats=%0d blkends=%0d required 9 1", beats, blkends);
    end
    n_tests++;
    if (obs.size() < 9 || obs[1].dw[2][5] !== 32'd518 || obs[8].blk !== 1'b1) begin
      n_fail++; $display("FAIL dw_s1_pixel: got %0d required 518", (obs.size() > 1) ? obs[1].dw[2][5] : 32'd0);
    end
  endtask

  task automatic test_dw_stride2();
    run_block(1'b0, 1'b1, 16, 100, 1'b0);
    n_tests++;
    if (beats != 9) begin
      n_fail++; $display("FAIL dw_s2_count: beats=%0d required 9", beats);
    end
    n_tests++;
    if (obs.size() < 3 || obs[2].dw[0][14] !== 32'd46) begin
      n_fail++; $display("FAIL dw_s2_x14: got %0d required 46", (obs.size() > 2) ? obs[2].dw[0][14] : 32'd0);
    end
    for (int y = 0; y < POY; y++) begin
      n_tests++;
      if (obs.size() < 3 || obs[2].dw[y][15] !== 32'd0) begin
        n_fail++; $display("FAIL dw_s2_pad row %0d: got %0d required 0", y, (obs.size() > 2) ? obs[2].dw[y][15] : 32'd0);
      end
    end
  endtask

  task automatic test_pw();
    run_block(1'b1, 1'b0, 40, 100, 1'b0);
    n_tests++;
    if (beats != 16 || blkends != 1) begin
      n_fail++; $display("FAIL pw_count: beats=%0d blkends=%0d required 16 1", beats, blkends);
    end
    n_tests++;
    if (obs.size() < 9 || obs[7].pw[1] !== 32'd303 || obs[8].pw[1] !== 32'd0) begin
      n_fail++; $display("FAIL pw_pixel: got %0d/%0d required 303/0",
                         (obs.size() > 8) ? obs[7].pw[1] : 32'd0, (obs.size() > 8) ? obs[8].pw[1] : 32'd0);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      run_block(1'b0, 1'(i % 2), 7 * i + 3, 50, 1'b0);
      n_tests++;
      if (beats != 9 || blkends != 1) begin
        n_fail++; $display("FAIL bp_count %0d: beats=%0d blkends=%0d required 9 1", i, beats, blkends);
      end
    end
    run_block(1'b1, 1'b0, 35, 50, 1'b0);
    n_tests++;
    if (beats != 16 || blkends != 1) begin
      n_fail++; $display("FAIL bp_pw_count: beats=%0d blkends=%0d required 16 1", beats, blkends);
    end
  endtask

  task automatic test_start_while_busy();
    logic woke;
    run_block(1'b0, 1'b0, 5, 70, 1'b1);
    n_tests++;
    if (beats != 9 || blkends != 1) begin
      n_fail++; $display("FAIL busy_start_count: beats=%0d blkends=%0d required 9 1", beats, blkends);
    end
    woke = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || out_valid !== 1'b0) woke = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (woke) begin
      n_fail++; $display("FAIL busy_start_restart: activity=1 required 0");
    end
  endtask

  task automatic test_reset_mid();
    int   acc, budget;
    logic seen;
    acc = 0; budget = 0; seen = 1'b0;
    @(negedge clk);
    start = 1'b1; cfg_mode = 1'b0; cfg_stride = 1'b0; cfg_col_base = '0;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    while (!(acc == 2 && out_valid === 1'b1) && budget < 200) begin
      if (in_ready === 1'b1) begin
        fill_data(acc); in_valid = 1'b1; acc++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (budget >= 200) begin
      n_fail++; $display("FAIL mid_reach_ky1: timeout acc=%0d required 2", acc);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, in_ready, blkend, busy} !== 4'b0000 || dwpixel_array !== '0 || pwpixel_array !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: v/r/b/busy=%b required 0000", {out_valid, in_ready, blkend, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL mid_reset_quiet: activity=1 required 0");
    end
    run_block(1'b0, 1'b0, 0, 100, 1'b0);
    n_tests++;
    if (beats != 9 || blkends != 1) begin
      n_fail++; $display("FAIL post_reset_block: beats=%0d blkends=%0d required 9 1", beats, blkends);
    end
  endtask

  initial begin
    test_reset();
    test_dw_stride1();
    test_dw_stride2();
    test_pw();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
